// File: rtl/fft_buf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | fft_buf_pkg                                                     |
// | Shared types and helpers for the FFT sample capture buffer.     |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
package fft_buf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        FROZEN = 2'd2,
        READ   = 2'd3
    } state_t;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    // Reverses the low nbits of value; upper bits of the result are zero.
    function automatic int unsigned bit_reverse(input int unsigned value, input int nbits);
        int unsigned r;
        r = 0;
        for (int i = 0; i < nbits; i++) begin
            r[i] = value[nbits-1-i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_sample_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------+
// | fft_sample_buffer_if                                            |
// | Input sample strobe and replay valid/ready stream.              |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
interface fft_sample_buffer_if #(
    parameter int DATA_W = 8
) ();
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, out_last
    );
endinterface
`default_nettype wire

// File: rtl/fft_buf_regfile.sv
`default_nettype none
// +----------------------------------------------------------------+
// | fft_buf_regfile                                                 |
// | Flop array, one synchronous write port, one async read port.    |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module fft_buf_regfile #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_W-1:0]     rdata
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];
endmodule
`default_nettype wire

// File: rtl/fft_sample_buffer.sv
`default_nettype none
// +----------------------------------------------------------------+
// | fft_sample_buffer                                               |
// | Captures a frame (one-shot or ring) and replays it oldest-first |
// | in natural or bit-reversed order over valid/ready.              |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module fft_sample_buffer
    import fft_buf_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 mode,
    input  logic                 bitrev,
    input  logic                 arm,
    input  logic                 read_req,
    fft_sample_buffer_if.slave   bus,
    output logic                 full,
    output logic                 dropped,
    output logic [1:0]           state
);
    localparam logic [DEPTH_LOG2:0] c_depth = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0] c_last  = c_depth - 1'b1;

    state_t                r_state, w_state_nxt;
    logic                  r_mode, r_bitrev, r_full, r_dropped;
    logic                  r_out_valid, r_out_last;
    logic [DATA_W-1:0]     r_out_data, w_rd_data;
    logic [DEPTH_LOG2-1:0] r_wr_ptr, r_base, w_base_nxt, w_rd_ofs, w_rd_addr;
    logic [DEPTH_LOG2:0]   r_cnt, r_rd_idx;
    logic                  w_arm, w_wr_en, w_load, w_hs, w_enter_read;

    // arm is honoured everywhere except during replay; a same-cycle arm in
    // FILL restarts the capture and discards that cycle's sample.
    assign w_arm        = arm && (r_state != READ);
    assign w_wr_en      = ena && (r_state == FILL) && bus.in_valid && !arm;
    assign w_base_nxt   = w_wr_en ? r_wr_ptr + 1'b1 : r_wr_ptr;
    assign w_rd_ofs     = r_bitrev ? DEPTH_LOG2'(bit_reverse(32'(r_rd_idx), DEPTH_LOG2))
                                   : r_rd_idx[DEPTH_LOG2-1:0];
    assign w_rd_addr    = r_base + w_rd_ofs;
    assign w_hs         = r_out_valid && bus.out_ready;
    assign w_load       = (r_state == READ) && (!r_out_valid || bus.out_ready)
                          && !r_rd_idx[DEPTH_LOG2];
    assign w_enter_read = (w_state_nxt == READ) && (r_state != READ);

    fft_buf_regfile #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_regfile (
        .clk   (clk),
        .we    (w_wr_en),
        .waddr (r_wr_ptr),
        .wdata (bus.in_data),
        .raddr (w_rd_addr),
        .rdata (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else if (ena) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (arm) w_state_nxt = FILL;
            end
            FILL: begin
                if (arm) begin
                    w_state_nxt = FILL;
                end else if (r_mode == MODE_ONESHOT && w_wr_en && r_cnt == c_last) begin
                    w_state_nxt = FROZEN;
                end else if (r_mode == MODE_RING && read_req && r_full) begin
                    w_state_nxt = READ;
                end
            end
            FROZEN: begin
                if (arm) begin
                    w_state_nxt = FILL;
                end else if (read_req) begin
                    w_state_nxt = READ;
                end
            end
            READ: begin
                if (w_hs && r_out_last) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode      <= MODE_RING;
            r_bitrev    <= 1'b0;
            r_wr_ptr    <= '0;
            r_cnt       <= '0;
            r_full      <= 1'b0;
            r_dropped   <= 1'b0;
            r_base      <= '0;
            r_rd_idx    <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else if (ena) begin
            if (w_arm) begin
                r_mode    <= mode;
                r_wr_ptr  <= '0;
                r_cnt     <= '0;
                r_full    <= 1'b0;
                r_dropped <= 1'b0;
            end else begin
                if (w_wr_en) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (r_cnt != c_depth) r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last)  r_full <= 1'b1;
                end
                if (bus.in_valid && r_state != FILL) r_dropped <= 1'b1;
            end

            if (w_enter_read) begin
                r_base   <= w_base_nxt;
                r_bitrev <= bitrev;
                r_rd_idx <= '0;
            end else if (w_load) begin
                r_out_data  <= w_rd_data;
                r_out_last  <= (r_rd_idx == c_last);
                r_out_valid <= 1'b1;
                r_rd_idx    <= r_rd_idx + 1'b1;
            end else if (w_hs) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign full          = r_full;
    assign dropped       = r_dropped;
    assign state         = r_state;
endmodule
`default_nettype wire

// File: tb/tb_fft_sample_buffer.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_fft_sample_buffer                                            |
// | Directed scenarios for the FFT sample capture buffer.           |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module tb_fft_sample_buffer;
    logic       clk = 1'b0;
    logic       rst_n, ena, mode, bitrev, arm, read_req;
    logic       full, dropped;
    logic [1:0] state;
    int         n_tests = 0;
    int         n_fail  = 0;

    logic [7:0] got [8];
    logic [7:0] got_last;
    int         got_n, got_cyc;

    always #5 clk = ~clk;

    fft_sample_buffer_if #(.DATA_W(8)) bif ();

    fft_sample_buffer #(
        .DATA_W     (8),
        .DEPTH_LOG2 (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .mode     (mode),
        .bitrev   (bitrev),
        .arm      (arm),
        .read_req (read_req),
        .bus      (bif),
        .full     (full),
        .dropped  (dropped),
        .state    (state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic m);
        arm = 1'b1; mode = m;
        step();
        arm = 1'b0;
    endtask

    task automatic feed(input logic [7:0] d);
        bif.in_valid = 1'b1; bif.in_data = d;
        step();
        bif.in_valid = 1'b0;
    endtask

    task automatic do_read(input logic b);
        read_req = 1'b1; bitrev = b;
        step();
        read_req = 1'b0;
    endtask

    // Gathers one frame with out_ready held high; got_cyc counts cycles from first valid.
    task automatic collect();
        got_n = 0; got_cyc = 0; got_last = '0;
        bif.out_ready = 1'b1;
        for (int c = 0; c < 40 && got_n < 8; c++) begin
            if (bif.out_valid) begin
                got[got_n]      = bif.out_data;
                got_last[got_n] = bif.out_last;
                got_n++;
            end
            if (got_n > 0) got_cyc++;
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; mode = 1'b0; bitrev = 1'b0; arm = 1'b0; read_req = 1'b0;
        bif.in_valid = 1'b0; bif.in_data = '0; bif.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (state !== 2'd0 || bif.out_valid !== 1'b0 || bif.out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: state=%0d valid=%b last=%b, required 0/0/0", state, bif.out_valid, bif.out_last);
        end
        n_tests++;
        if (bif.out_data !== 8'h00 || full !== 1'b0 || dropped !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: data=%h full=%b dropped=%b, required 00/0/0", bif.out_data, full, dropped);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_oneshot_natural();
        logic [7:0] e;
        do_arm(1'b1);
        n_tests++;
        if (state !== 2'd1) begin n_fail++; $display("FAIL arm_state: got %0d, required 1", state); end
        for (int k = 0; k < 8; k++) feed(8'h10 + 8'(k));
        n_tests++;
        if (state !== 2'd2 || full !== 1'b1) begin
            n_fail++; $display("FAIL oneshot_frozen: state=%0d full=%b, required 2/1", state, full);
        end
        do_read(1'b0);
        n_tests++;
        if (state !== 2'd3 || bif.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL read_entry: state=%0d valid=%b, required 3/0", state, bif.out_valid);
        end
        collect();
        n_tests++;
        if (got_n !== 8 || got_cyc !== 8) begin
            n_fail++; $display("FAIL nat_count: samples=%0d cycles=%0d, required 8/8", got_n, got_cyc);
        end
        for (int k = 0; k < 8; k++) begin
            e = 8'h10 + 8'(k);
            n_tests++;
            if (got[k] !== e) begin n_fail++; $display("FAIL nat_data[%0d]: got %h, required %h", k, got[k], e); end
        end
        n_tests++;
        if (got_last !== 8'h80) begin n_fail++; $display("FAIL nat_last: got %b, required 10000000", got_last); end
        n_tests++;
        if (state !== 2'd0 || bif.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL nat_end: state=%0d valid=%b, required 0/0", state, bif.out_valid);
        end
    endtask

    task automatic test_oneshot_bitrev();
        logic [7:0] exp_br [8];
        exp_br = '{8'h10, 8'h14, 8'h12, 8'h16, 8'h11, 8'h15, 8'h13, 8'h17};
        do_arm(1'b1);
        for (int k = 0; k < 8; k++) feed(8'h10 + 8'(k));
        do_read(1'b1);
        collect();
        n_tests++;
        if (got_n !== 8) begin n_fail++; $display("FAIL br_count: got %0d, required 8", got_n); end
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (got[k] !== exp_br[k]) begin
                n_fail++; $display("FAIL br_data[%0d]: got %h, required %h", k, got[k], exp_br[k]);
            end
        end
        n_tests++;
        if (got_last !== 8'h80) begin n_fail++; $display("FAIL br_last: got %b, required 10000000", got_last); end
    endtask

    task automatic test_ring_wrap();
        logic [7:0] e;
        do_arm(1'b0);
        for (int k = 0; k < 12; k++) feed(8'(k));
        n_tests++;
        if (state !== 2'd1 || full !== 1'b1 || dropped !== 1'b0) begin
            n_fail++; $display("FAIL ring_flags: state=%0d full=%b dropped=%b, required 1/1/0", state, full, dropped);
        end
        do_read(1'b0);
        collect();
        n_tests++;
        if (got_n !== 8) begin n_fail++; $display("FAIL ring_count: got %0d, required 8", got_n); end
        for (int k = 0; k < 8; k++) begin
            e = 8'h04 + 8'(k);
            n_tests++;
            if (got[k] !== e) begin n_fail++; $display("FAIL ring_data[%0d]: got %h, required %h", k, got[k], e); end
        end
    endtask

    task automatic test_back_pressure();
        logic [3:0] pat;
        logic       prev_stall, prev_last;
        logic [7:0] prev_d, e;
        int         n, viol;
        pat = 4'b1001; prev_stall = 1'b0; prev_last = 1'b0; prev_d = '0; n = 0; viol = 0;
        do_arm(1'b1);
        for (int k = 0; k < 8; k++) feed(8'h50 + 8'(k));
        do_read(1'b0);
        for (int c = 0; c < 80 && n < 8; c++) begin
            bif.out_ready = pat[c % 4];
            if (prev_stall && (!bif.out_valid || bif.out_data !== prev_d || bif.out_last !== prev_last)) viol++;
            prev_stall = bif.out_valid && !bif.out_ready;
            prev_d     = bif.out_data;
            prev_last  = bif.out_last;
            if (bif.out_valid && bif.out_ready) begin
                got[n] = bif.out_data;
                n++;
            end
            step();
        end
        bif.out_ready = 1'b1;
        n_tests++;
        if (n !== 8) begin n_fail++; $display("FAIL bp_handshakes: got %0d, required 8", n); end
        n_tests++;
        if (viol !== 0) begin n_fail++; $display("FAIL bp_stable: %0d unstable stalls, required 0", viol); end
        for (int k = 0; k < 8; k++) begin
            e = 8'h50 + 8'(k);
            n_tests++;
            if (got[k] !== e) begin n_fail++; $display("FAIL bp_data[%0d]: got %h, required %h", k, got[k], e); end
        end
        step();
        n_tests++;
        if (state !== 2'd0 || bif.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_end: state=%0d valid=%b, required 0/0", state, bif.out_valid);
        end
    endtask

    task automatic test_boundary();
        logic [7:0] e;
        do_arm(1'b0);
        for (int k = 0; k < 5; k++) feed(8'(k));
        do_read(1'b0);
        n_tests++;
        if (state !== 2'd1 || full !== 1'b0) begin
            n_fail++; $display("FAIL early_read: state=%0d full=%b, required 1/0", state, full);
        end
        // Re-arm from FILL restarts the count; eight more samples must freeze.
        do_arm(1'b1);
        for (int k = 0; k < 8; k++) feed(8'h20 + 8'(k));
        n_tests++;
        if (state !== 2'd2 || dropped !== 1'b0) begin
            n_fail++; $display("FAIL rearm_frozen: state=%0d dropped=%b, required 2/0", state, dropped);
        end
        feed(8'hEE);
        n_tests++;
        if (dropped !== 1'b1 || state !== 2'd2) begin
            n_fail++; $display("FAIL frozen_drop: dropped=%b state=%0d, required 1/2", dropped, state);
        end
        do_read(1'b0);
        collect();
        for (int k = 0; k < 8; k++) begin
            e = 8'h20 + 8'(k);
            n_tests++;
            if (got[k] !== e) begin n_fail++; $display("FAIL frozen_data[%0d]: got %h, required %h", k, got[k], e); end
        end
        do_arm(1'b0);
        n_tests++;
        if (dropped !== 1'b0) begin n_fail++; $display("FAIL arm_clear_drop: got %b, required 0", dropped); end
        for (int k = 0; k < 12; k++) feed(8'(k));
        read_req = 1'b1; bif.in_valid = 1'b1; bif.in_data = 8'h0C;
        step();
        read_req = 1'b0; bif.in_valid = 1'b0;
        n_tests++;
        if (state !== 2'd3) begin n_fail++; $display("FAIL same_cycle_read: state=%0d, required 3", state); end
        collect();
        for (int k = 0; k < 8; k++) begin
            e = 8'h05 + 8'(k);
            n_tests++;
            if (got[k] !== e) begin n_fail++; $display("FAIL same_cycle_data[%0d]: got %h, required %h", k, got[k], e); end
        end
        feed(8'h99);
        n_tests++;
        if (dropped !== 1'b1) begin n_fail++; $display("FAIL idle_drop: got %b, required 1", dropped); end
    endtask

    task automatic test_reset_enable();
        logic       found;
        logic [7:0] e;
        found = 1'b0;
        do_arm(1'b1);
        for (int k = 0; k < 8; k++) feed(8'h30 + 8'(k));
        bif.out_ready = 1'b1;
        do_read(1'b0);
        for (int c = 0; c < 30 && !found; c++) begin
            if (bif.out_valid && bif.out_data == 8'h33) found = 1'b1;
            else step();
        end
        n_tests++;
        if (!found) begin n_fail++; $display("FAIL reach_sample3: not seen, required within 30 cycles"); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (bif.out_valid !== 1'b0 || state !== 2'd0 || bif.out_data !== 8'h00 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b state=%0d data=%h full=%b, required 0/0/00/0",
                     bif.out_valid, state, bif.out_data, full);
        end
        step();
        rst_n = 1'b1;
        step();
        n_tests++;
        if (state !== 2'd0 || bif.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset: state=%0d valid=%b, required 0/0", state, bif.out_valid);
        end
        do_arm(1'b1);
        for (int k = 0; k < 3; k++) feed(8'h40 + 8'(k));
        ena = 1'b0; bif.in_valid = 1'b1; bif.in_data = 8'hFF;
        repeat (3) step();
        n_tests++;
        if (dut.r_cnt !== 4'd3 || dut.r_wr_ptr !== 3'd3 || state !== 2'd1) begin
            n_fail++;
            $display("FAIL ena_hold: cnt=%0d wr_ptr=%0d state=%0d, required 3/3/1", dut.r_cnt, dut.r_wr_ptr, state);
        end
        bif.in_valid = 1'b0; ena = 1'b1;
        for (int k = 3; k < 8; k++) feed(8'h40 + 8'(k));
        do_read(1'b0);
        collect();
        for (int k = 0; k < 8; k++) begin
            e = 8'h40 + 8'(k);
            n_tests++;
            if (got[k] !== e) begin n_fail++; $display("FAIL ena_data[%0d]: got %h, required %h", k, got[k], e); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_oneshot_natural();
        test_oneshot_bitrev();
        test_ring_wrap();
        test_back_pressure();
        test_boundary();
        test_reset_enable();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fft_sample_buffer.md
# fft_sample_buffer

Parametrised capture buffer that sits in front of the FFT datapath. It records a frame of `DEPTH` input samples, either once or continuously into a ring, then freezes and replays the frame over a valid/ready stream. Replay is oldest-first, in natural or bit-reversed index order, so the butterfly stage can consume it directly. It replaces the fixed-width free-running shift register with addressable storage, arm/read control and back-pressure.

## Interface

Parameters:
- `DATA_W`, 8: sample width in bits.
- `DEPTH_LOG2`, 4: log2 of frame length; `DEPTH = 2**DEPTH_LOG2`, legal range 2..6.

Ports (reset `rst_n`, asynchronous, active-low; clock `clk`):
- `clk` input 1: clock, all state on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `ena` input 1: global enable. When 0, all state holds, no writes occur, and outputs hold.
- `mode` input 1: 0 = continuous ring capture, 1 = one-shot capture. Sampled only on `arm`.
- `bitrev` input 1: 0 = natural replay order, 1 = bit-reversed. Sampled only on read start.
- `arm` input 1: single-cycle request to start a capture.
- `read_req` input 1: single-cycle request to freeze and replay.
- `in_valid` input 1: input sample strobe.
- `in_data` input `DATA_W`: input sample.
- `out_valid` output 1: replay sample valid.
- `out_ready` input 1: downstream accepts a sample.
- `out_data` output `DATA_W`: replay sample.
- `out_last` output 1: asserted with the final sample of a frame.
- `full` output 1: at least `DEPTH` samples captured since `arm`.
- `dropped` output 1: sticky flag, set when `in_valid` is asserted outside FILL; cleared on `arm`.
- `state` output 2: current FSM state encoding.

## Operation

- States: IDLE=0, FILL=1, FROZEN=2, READ=3. After reset the FSM is in IDLE and `wr_ptr`, `cnt`, `rd_idx`, `full`, `dropped`, `out_valid`, `out_last` and `out_data` are all 0. Storage is not reset.
- IDLE, on `arm`: go to FILL. Latch `mode`, clear `wr_ptr`, `cnt`, `full` and `dropped`.
- FILL, on `in_valid`:
  - write `mem[wr_ptr] <= in_data` and set `wr_ptr <= wr_ptr+1` (mod `DEPTH`, wraps).
  - `cnt` saturates at `DEPTH`; `full` is set when `cnt` reaches `DEPTH`.
- FILL with `mode`=1: the write that makes `cnt==DEPTH` moves the FSM to FROZEN. `wr_ptr` has wrapped to 0.
- FILL with `mode`=0: keep overwriting the ring. On `read_req` with `full`=1, go to READ. If `in_valid` is asserted on the same cycle, that sample is written first, then the freeze takes effect.
- FILL, `read_req` with `full`=0: ignored.
- FILL, `arm`: restarts capture (same actions as from IDLE).
- FROZEN, on `read_req`: go to READ.
- Entering READ: latch `base <= wr_ptr`, which is the oldest sample after any same-cycle write. Latch `bitrev` and clear `rd_idx`.
- READ replay order: sample k (0..`DEPTH`-1) is read from address `(base + (bitrev ? rev(k) : k)) mod DEPTH`. `rev` reverses `DEPTH_LOG2` bits.
- Output register: loads a new sample when `!out_valid || out_ready` and `rd_idx < DEPTH`, then increments `rd_idx`. `out_last` is asserted with k=`DEPTH`-1.
- Handshake: `out_data`, `out_last` and `out_valid` stay stable while `out_valid && !out_ready`.
- End of frame: the handshake of the last sample (`out_valid && out_ready && out_last`) returns the FSM to IDLE, with `out_valid` low on the next cycle.
- `arm` and `read_req` are ignored in READ and in IDLE (`read_req` only).
- `in_valid` asserted outside FILL is dropped and sets `dropped`.

## Timing

- Write latency: a sample accepted at edge N is stored at N.
- READ is entered at edge N. The first `out_valid` is high after edge N+1.
- Throughput is 1 sample/cycle with `out_ready` held at 1. A full frame occupies `DEPTH` consecutive `out_valid` cycles.
- IDLE is reached at the edge of the last handshake.
- With `ena`=0 on any cycle, that edge is a no-op for all registers, including the handshake.
- Reset asserted mid-FILL or mid-READ: outputs go to their reset values immediately (asynchronously) and the FSM is in IDLE after release. The partial frame is discarded.

## Structure

- Package `fft_buf_pkg`:
  - state enum (IDLE, FILL, FROZEN, READ with the encodings above);
  - `bit_reverse(value, nbits)` function;
  - mode constants `MODE_RING`=0 and `MODE_ONESHOT`=1.
- Sub-module `fft_buf_regfile`: parametrised `DEPTH`×`DATA_W` flop array with one synchronous write port and one combinational read port.
- The FSM, pointers and output register live in the top module.

## Test plan

All scenarios use `DATA_W`=8, `DEPTH_LOG2`=3.

- One-shot, natural order: `arm` with `mode`=1, feed 0x10..0x17, then `read_req` with `bitrev`=0 and `out_ready`=1. Expect out 0x10..0x17 on consecutive cycles, `out_last` with 0x17, `state` back to 0.
- One-shot, bit-reversed: same capture, `read_req` with `bitrev`=1. Expect out 0x10,0x14,0x12,0x16,0x11,0x15,0x13,0x17.
- Ring wrap: `mode`=0, feed 0x00..0x0B, then `read_req`. Expect 0x04..0x0B, `full`=1, `dropped`=0.
- Back-pressure: toggle `out_ready` in the pattern 1,0,0,1,… during replay. Expect `out_data` stable while stalled, no sample lost or duplicated, exactly 8 handshakes.
- Boundary events:
  - `read_req` with 5 samples in ring mode is ignored;
  - `in_valid` in FROZEN sets `dropped` and leaves storage unchanged;
  - `read_req` together with `in_valid`=0x0C in ring mode after 0x00..0x0B makes the replay start at 0x05.
- Reset and enable: assert `rst_n`=0 at sample 3 of a replay. Expect `out_valid`=0 immediately and `state`=0. Re-arm, and hold `ena`=0 for 3 cycles mid-fill: `cnt` and `wr_ptr` must not change.
